// File: rtl/lcv_mul_acc_arb_if.sv
// Request/result bundle for the shared multiply-accumulate arbiter.
// The master drives requests and out_ready; the slave (the arbiter) drives grants and results.
interface lcv_mul_acc_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*16-1:0] req_a;
  logic [NUM_REQ*16-1:0] req_b;
  logic [NUM_REQ*33-1:0] req_c;
  logic [NUM_REQ-1:0]    req_acc;
  logic                  out_valid;
  logic                  out_ready;
  logic [32:0]           out_data;
  logic [ID_W-1:0]       out_id;

  modport master (
    output req_valid, req_a, req_b, req_c, req_acc, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, req_acc, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/lcv_mul_acc_arb.sv
// Round-robin arbiter feeding one signed 16x16+33 MAC with a single-entry result register.
// Each requester owns a private 33-bit accumulator that is updated on every accept it wins.
module lcv_mul_acc_arb #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input logic              clk,
  input logic              rst,
  lcv_mul_acc_arb_if.slave bus
);
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_found;
  logic [ID_W:0]      cand;
  logic               load_ok;
  logic               accept;
  logic [NUM_REQ-1:0] grant;

  logic signed [15:0] a_arr   [NUM_REQ];
  logic signed [15:0] b_arr   [NUM_REQ];
  logic signed [32:0] c_arr   [NUM_REQ];
  logic signed [32:0] acc_q   [NUM_REQ];
  logic signed [31:0] prod;
  logic signed [32:0] c_eff;
  logic signed [32:0] result;

  logic               out_valid_q;
  logic [32:0]        out_data_q;
  logic [ID_W-1:0]    out_id_q;

  // Search upward from ptr; the one-bit-wider candidate lets NUM_REQ be any value in range.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, ptr} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!gnt_found && bus.req_valid[cand[ID_W-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = cand[ID_W-1:0];
      end
    end
  end

  assign load_ok       = !out_valid_q || bus.out_ready;
  assign accept        = gnt_found && load_ok && !rst;
  assign grant         = accept ? (NUM_REQ'(1) << gnt_id) : '0;
  assign bus.req_ready = grant;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = bus.req_a[i*16 +: 16];
      b_arr[i] = bus.req_b[i*16 +: 16];
      c_arr[i] = bus.req_c[i*33 +: 33];
    end
    prod   = a_arr[gnt_id] * b_arr[gnt_id];
    c_eff  = bus.req_acc[gnt_id] ? acc_q[gnt_id] : c_arr[gnt_id];
    result = {prod[31], prod} + c_eff;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      ptr         <= '0;
      for (int j = 0; j < NUM_REQ; j++)
        acc_q[j] <= '0;
    end else if (accept) begin
      out_valid_q    <= 1'b1;
      out_data_q     <= result;
      out_id_q       <= gnt_id;
      acc_q[gnt_id]  <= result;
      ptr            <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_id    = out_id_q;
endmodule
